// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcode, ALU-op, memory-size and control-bundle types
// Purpose: common definitions for the pipelined MIPS main-control path.
// Ports: none (package).
package mips_ctrl_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_LH    = 6'h21;
  localparam logic [OPC_W-1:0] OP_LHU   = 6'h25;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    MEM_WORD  = 2'b00,
    MEM_HALF  = 2'b01,
    MEM_HALFU = 2'b10
  } mem_size_e;

  typedef struct packed {
    logic       reg_dest;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    mem_size_e  mem_size;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-bundle decoder
// Purpose: maps the ID-stage opcode to a ctrl_t bundle; unknown opcodes
//          produce an all-zero bundle with only the illegal flag set.
// Ports:
//   opcode  in   OPC_W  ID-stage opcode
//   ctrl    out  ctrl_t decoded control bundle
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dest  = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        ctrl.reg_write = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.reg_write = 1'b1;
      end
      OP_LW, OP_LH, OP_LHU: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.reg_write  = 1'b1;
        if (opcode == OP_LH) begin
          ctrl.mem_size = MEM_HALF;
        end else if (opcode == OP_LHU) begin
          ctrl.mem_size = MEM_HALFU;
        end else begin
          ctrl.mem_size = MEM_WORD;
        end
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipelined main control with load-use stall and branch flush
// Purpose: decodes the ID opcode, carries the control bundle through ID/EX,
//          EX/MEM and MEM/WB, stalls ID on load-use and squashes ID on a
//          taken branch in EX.
// Ports:
//   clk, reset                 clock (rising) and async active-low reset
//   id_valid/opCode/rs/rt      ID-stage instruction
//   branch_taken               EX branch comparison result
//   id_stall                   hold PC and IF/ID (combinational)
//   ex_*                       EX-stage controls (registered)
//   mem_*                      MEM-stage controls (registered)
//   wb_*                       WB-stage controls (registered)
module pipe_ctrl_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 2,
  parameter int HAZARD_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opCode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                branch_taken,
  output logic                id_stall,
  output logic                ex_valid,
  output logic                ex_regDest,
  output logic                ex_aluSrc,
  output logic                ex_branch,
  output logic                ex_branchNe,
  output logic                ex_illegal,
  output logic [ALUOP_W-1:0]  ex_aluOp,
  output logic                mem_valid,
  output logic                mem_memRead,
  output logic                mem_memWrite,
  output logic [1:0]          mem_memSize,
  output logic                wb_valid,
  output logic                wb_regWrite,
  output logic                wb_memToReg
);

  ctrl_t id_ctrl;

  ctrl_decode u_decode (
    .opcode (id_opCode),
    .ctrl   (id_ctrl)
  );

  logic             ex_valid_q, ex_valid_d;
  ctrl_t            ex_ctrl_q, ex_ctrl_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;

  logic      mem_valid_q, mem_valid_d;
  logic      mem_read_q, mem_read_d;
  logic      mem_write_q, mem_write_d;
  mem_size_e mem_size_q, mem_size_d;
  logic      mem_reg_write_q, mem_reg_write_d;
  logic      mem_to_reg_q, mem_to_reg_d;

  logic wb_valid_q, wb_valid_d;
  logic wb_reg_write_q, wb_reg_write_d;
  logic wb_mem_to_reg_q, wb_mem_to_reg_d;

  logic load_use;
  logic flush;
  logic issue;

  always_comb begin
    load_use = (HAZARD_EN != 0) && ex_valid_q && ex_ctrl_q.mem_read && id_valid &&
               ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
    // bne is taken when the equality compare fails, hence the XOR.
    flush    = ex_valid_q && ex_ctrl_q.branch && (branch_taken ^ ex_ctrl_q.branch_ne);
    issue    = id_valid && !load_use && !flush;

    // Illegal opcodes travel as a bubble that only carries the illegal flag.
    ex_valid_d = issue && !id_ctrl.illegal;
    ex_ctrl_d  = CTRL_NOP;
    if (ex_valid_d) begin
      ex_ctrl_d = id_ctrl;
    end
    ex_ctrl_d.illegal = issue && id_ctrl.illegal;
    ex_rt_d = ex_valid_d ? id_rt : '0;

    // Bubble bundles are already all-zero, so later stages just copy.
    mem_valid_d     = ex_valid_q;
    mem_read_d      = ex_ctrl_q.mem_read;
    mem_write_d     = ex_ctrl_q.mem_write;
    mem_size_d      = ex_ctrl_q.mem_size;
    mem_reg_write_d = ex_ctrl_q.reg_write;
    mem_to_reg_d    = ex_ctrl_q.mem_to_reg;

    wb_valid_d      = mem_valid_q;
    wb_reg_write_d  = mem_reg_write_q;
    wb_mem_to_reg_d = mem_to_reg_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q      <= 1'b0;
      ex_ctrl_q       <= CTRL_NOP;
      ex_rt_q         <= '0;
      mem_valid_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_size_q      <= MEM_WORD;
      mem_reg_write_q <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_ctrl_q       <= ex_ctrl_d;
      ex_rt_q         <= ex_rt_d;
      mem_valid_q     <= mem_valid_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_size_q      <= mem_size_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
    end
  end

  assign id_stall     = load_use && !flush;
  assign ex_valid     = ex_valid_q;
  assign ex_regDest   = ex_ctrl_q.reg_dest;
  assign ex_aluSrc    = ex_ctrl_q.alu_src;
  assign ex_branch    = ex_ctrl_q.branch;
  assign ex_branchNe  = ex_ctrl_q.branch_ne;
  assign ex_illegal   = ex_ctrl_q.illegal;
  assign ex_aluOp     = ex_ctrl_q.alu_op;
  assign mem_valid    = mem_valid_q;
  assign mem_memRead  = mem_read_q;
  assign mem_memWrite = mem_write_q;
  assign mem_memSize  = mem_size_q;
  assign wb_valid     = wb_valid_q;
  assign wb_regWrite  = wb_reg_write_q;
  assign wb_memToReg  = wb_mem_to_reg_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid;
  logic [5:0] id_opCode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       branch_taken;

  logic       id_stall, ex_valid, ex_regDest, ex_aluSrc, ex_branch, ex_branchNe, ex_illegal;
  logic [1:0] ex_aluOp;
  logic       mem_valid, mem_memRead, mem_memWrite;
  logic [1:0] mem_memSize;
  logic       wb_valid, wb_regWrite, wb_memToReg;
  wire [16:0] h0_o;
  wire [16:0] dut_vec;

  assign dut_vec = {id_stall, ex_valid, ex_regDest, ex_aluSrc, ex_branch, ex_branchNe,
                    ex_illegal, ex_aluOp, mem_valid, mem_memRead, mem_memWrite,
                    mem_memSize, wb_valid, wb_regWrite, wb_memToReg};

  pipe_ctrl_unit #(.OPCODE_W(6), .REG_W(5), .ALUOP_W(2), .HAZARD_EN(1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opCode(id_opCode),
    .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_regDest(ex_regDest),
    .ex_aluSrc(ex_aluSrc), .ex_branch(ex_branch), .ex_branchNe(ex_branchNe),
    .ex_illegal(ex_illegal), .ex_aluOp(ex_aluOp), .mem_valid(mem_valid),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .mem_memSize(mem_memSize),
    .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg)
  );

  pipe_ctrl_unit #(.OPCODE_W(6), .REG_W(5), .ALUOP_W(2), .HAZARD_EN(0)) h0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opCode(id_opCode),
    .id_rs(id_rs), .id_rt(id_rt), .branch_taken(branch_taken),
    .id_stall(h0_o[16]), .ex_valid(h0_o[15]), .ex_regDest(h0_o[14]),
    .ex_aluSrc(h0_o[13]), .ex_branch(h0_o[12]), .ex_branchNe(h0_o[11]),
    .ex_illegal(h0_o[10]), .ex_aluOp(h0_o[9:8]), .mem_valid(h0_o[7]),
    .mem_memRead(h0_o[6]), .mem_memWrite(h0_o[5]), .mem_memSize(h0_o[4:3]),
    .wb_valid(h0_o[2]), .wb_regWrite(h0_o[1]), .wb_memToReg(h0_o[0])
  );

  // Model: each stage slot holds the instruction that occupies it.
  typedef struct packed {
    logic       v;
    logic       ill;
    logic [5:0] op;
    logic [4:0] rt;
  } slot_t;

  typedef struct packed {
    slot_t ex;
    slot_t mem;
    slot_t wb;
  } mstate_t;

  typedef struct packed {
    logic       legal, rd, as;
    logic [1:0] aop;
    logic       br, bne, mr, mw;
    logic [1:0] ms;
    logic       rw, m2r;
  } dec_t;

  function automatic dec_t dec(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      6'h00: begin d.legal = 1; d.rd = 1; d.aop = 2'b10; d.rw = 1; end
      6'h08: begin d.legal = 1; d.as = 1; d.rw = 1; end
      6'h23: begin d.legal = 1; d.as = 1; d.mr = 1; d.m2r = 1; d.rw = 1; d.ms = 2'b00; end
      6'h21: begin d.legal = 1; d.as = 1; d.mr = 1; d.m2r = 1; d.rw = 1; d.ms = 2'b01; end
      6'h25: begin d.legal = 1; d.as = 1; d.mr = 1; d.m2r = 1; d.rw = 1; d.ms = 2'b10; end
      6'h2B: begin d.legal = 1; d.as = 1; d.mw = 1; end
      6'h04: begin d.legal = 1; d.br = 1; d.aop = 2'b01; end
      6'h05: begin d.legal = 1; d.br = 1; d.bne = 1; d.aop = 2'b01; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic hazard(input mstate_t s, input logic en, input logic v,
                                  input logic [4:0] rs, input logic [4:0] rt);
    return en && s.ex.v && dec(s.ex.op).mr && v && (s.ex.rt == rs || s.ex.rt == rt);
  endfunction

  function automatic logic taken(input mstate_t s, input logic bt);
    return s.ex.v && dec(s.ex.op).br && (bt != (s.ex.op == 6'h05));
  endfunction

  function automatic logic [16:0] model_out(input mstate_t s, input logic en, input logic v,
                                            input logic [4:0] rs, input logic [4:0] rt,
                                            input logic bt);
    dec_t e, m, w;
    logic [16:0] o;
    e = dec(s.ex.op);
    m = dec(s.mem.op);
    w = dec(s.wb.op);
    o = '0;
    o[16] = hazard(s, en, v, rs, rt) && !taken(s, bt);
    if (s.ex.v) o[15:8] = {1'b1, e.rd, e.as, e.br, e.bne, 1'b0, e.aop};
    else        o[10]   = s.ex.ill;
    if (s.mem.v) o[7:3] = {1'b1, m.mr, m.mw, m.ms};
    if (s.wb.v)  o[2:0] = {1'b1, w.rw, w.m2r};
    return o;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic en, input logic v,
                                         input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic bt);
    mstate_t n;
    logic go;
    go    = v && !hazard(s, en, v, rs, rt) && !taken(s, bt);
    n.wb  = s.mem;
    n.mem = s.ex.v ? s.ex : '0;
    n.ex  = '0;
    if (go && dec(op).legal) begin
      n.ex.v  = 1'b1;
      n.ex.op = op;
      n.ex.rt = rt;
    end else if (go) begin
      n.ex.ill = 1'b1;
    end
    return n;
  endfunction

  mstate_t st, st0;
  int      checks = 0;
  int      errors = 0;
  logic    last_stall = 1'b0;

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive ID inputs, compare both DUTs with the model, advance the model.
  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic bt);
    logic [16:0] e1, e0;
    @(posedge clk);
    #1;
    id_valid = v; id_opCode = op; id_rs = rs; id_rt = rt; branch_taken = bt;
    @(negedge clk);
    e1 = model_out(st,  1'b1, v, rs, rt, bt);
    e0 = model_out(st0, 1'b0, v, rs, rt, bt);
    chk("stall",    17'(dut_vec[16]),   17'(e1[16]));
    chk("ex",       17'(dut_vec[15:8]), 17'(e1[15:8]));
    chk("mem",      17'(dut_vec[7:3]),  17'(e1[7:3]));
    chk("wb",       17'(dut_vec[2:0]),  17'(e1[2:0]));
    chk("h0_stall", 17'(h0_o[16]),      17'(e0[16]));
    chk("h0_ex",    17'(h0_o[15:8]),    17'(e0[15:8]));
    chk("h0_mem",   17'(h0_o[7:3]),     17'(e0[7:3]));
    chk("h0_wb",    17'(h0_o[2:0]),     17'(e0[2:0]));
    last_stall = e1[16];
    st  = model_next(st,  1'b1, v, op, rs, rt, bt);
    st0 = model_next(st0, 1'b0, v, op, rs, rt, bt);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    chk("reset_async",    dut_vec, 17'h0);
    chk("reset_async_h0", 17'(h0_o), 17'h0);
    id_valid = 1'b0;
    st = '0; st0 = '0; last_stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h23, 6'h21, 6'h25, 6'h2B, 6'h04, 6'h05, 6'h3F, 6'h17};
  logic       gv;
  logic [5:0] gop;
  logic [4:0] grs, grt;

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_opCode = '0; id_rs = '0; id_rt = '0; branch_taken = 1'b0;
    st = '0; st0 = '0;
    #2 reset = 1'b0;
    #1 chk("reset_initial", dut_vec, 17'h0);
    #20 reset = 1'b1;

    // R-type: EX one cycle later, WB three cycles later
    drive(1, 6'h00, 5'd1, 5'd2, 0);
    drive(0, 6'h00, 5'd0, 5'd0, 0);
    chk("rtype_ex", 17'({ex_valid, ex_regDest, ex_aluOp}), 17'b1110);
    drive(0, 6'h00, 5'd0, 5'd0, 0);
    drive(0, 6'h00, 5'd0, 5'd0, 0);
    chk("rtype_wb", 17'({wb_valid, wb_regWrite, wb_memToReg}), 17'b110);

    // lw rt=9 then add rs=9: one stall, one bubble, add one cycle late
    drive(1, 6'h23, 5'd0, 5'd9, 0);
    drive(1, 6'h00, 5'd9, 5'd3, 0);
    chk("lu_stall", 17'(id_stall), 17'd1);
    chk("lu_h0_nostall", 17'(h0_o[16]), 17'd0);
    drive(1, 6'h00, 5'd9, 5'd3, 0);
    chk("lu_bubble", 17'({ex_valid, id_stall}), 17'b00);
    drive(0, 6'h00, 5'd0, 5'd0, 0);
    chk("lu_add_ex", 17'({ex_valid, ex_regDest}), 17'b11);

    // branch squash cases
    drive(1, 6'h04, 5'd1, 5'd2, 0);
    drive(1, 6'h08, 5'd4, 5'd5, 1);
    drive(0, 6'h00, 5'd0, 5'd0, 0);
    chk("beq_taken_squash", 17'(ex_valid), 17'd0);
    drive(1, 6'h05, 5'd1, 5'd2, 0);
    drive(1, 6'h08, 5'd4, 5'd5, 0);
    drive(0, 6'h00, 5'd0, 5'd0, 0);
    chk("bne_taken_squash", 17'(ex_valid), 17'd0);
    drive(1, 6'h04, 5'd1, 5'd2, 0);
    drive(1, 6'h08, 5'd4, 5'd5, 0);
    drive(0, 6'h00, 5'd0, 5'd0, 0);
    chk("beq_not_taken", 17'({ex_valid, ex_aluSrc}), 17'b11);

    // lh, lhu, illegal
    drive(1, 6'h21, 5'd1, 5'd2, 0);
    drive(1, 6'h25, 5'd3, 5'd4, 0);
    drive(1, 6'h3F, 5'd5, 5'd6, 0);
    chk("lh_size", 17'(mem_memSize), 17'd1);
    drive(0, 6'h00, 5'd0, 5'd0, 0);
    chk("lhu_size", 17'(mem_memSize), 17'd2);
    chk("illegal_ex", 17'({ex_valid, ex_regDest, ex_aluSrc, ex_branch, ex_branchNe,
                           ex_illegal, ex_aluOp}), 17'b100);
    drive(0, 6'h00, 5'd0, 5'd0, 0);
    chk("illegal_one_cycle", 17'(ex_illegal), 17'd0);

    // reset asserted while a load-use stall is in progress
    drive(1, 6'h23, 5'd0, 5'd9, 0);
    drive(1, 6'h00, 5'd9, 5'd3, 0);
    do_reset();

    // randomized traffic; the bench plays IF/ID and holds ID while stalled
    gv = 0; gop = '0; grs = '0; grt = '0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      if (!last_stall) begin
        gv  = ($urandom_range(0, 7) != 0);
        gop = ops[$urandom_range(0, 9)];
        grs = 5'($urandom_range(0, 3));
        grt = 5'($urandom_range(0, 3));
      end
      drive(gv, gop, grs, grt, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined successor to the single-cycle main control decoder. It decodes the ID-stage opcode into a control bundle, carries that bundle through ID/EX, EX/MEM and MEM/WB registers, and detects load-use hazards (stall plus bubble) and taken-branch flushes. It sits between the IF/ID register and the datapath of the 5-stage MIPS core.

## Interface
- OPCODE_W, 6, opcode width
- REG_W, 5, register-address width
- ALUOP_W, 2, ALU-op code width
- HAZARD_EN, 1, 1 enables load-use stall; 0 ties id_stall low
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all pipeline state
- id_valid  in  1  ID holds a real instruction
- id_opCode  in  OPCODE_W  opcode of ID instruction
- id_rs, id_rt  in  REG_W  source register fields of ID instruction
- branch_taken  in  1  EX branch comparison result; qualified internally by ex_valid & ex_branch
- id_stall  out  1  hold PC and IF/ID this cycle
- ex_valid, ex_regDest, ex_aluSrc, ex_branch, ex_branchNe, ex_illegal  out  1  EX-stage controls
- ex_aluOp  out  ALUOP_W  EX ALU op
- mem_valid, mem_memRead, mem_memWrite  out  1  MEM-stage controls
- mem_memSize  out  2  00 word, 01 half signed, 10 half unsigned
- wb_valid, wb_regWrite, wb_memToReg  out  1  WB-stage controls

## Operation
- Decode (combinational on id_opCode): 0x00 R-type: regDest=1, aluOp=10, regWrite=1. 0x08 addi: aluSrc=1, aluOp=00, regWrite=1. 0x23 lw / 0x21 lh / 0x25 lhu: memRead=1, memToReg=1, aluSrc=1, aluOp=00, regWrite=1, memSize 00/01/10. 0x2B sw: memWrite=1, aluSrc=1, aluOp=00. 0x04 beq: branch=1, aluOp=01. 0x05 bne: branch=1, branchNe=1, aluOp=01. Any other opcode: all controls 0, illegal=1.
- Every control field of a bubble or non-valid slot is 0; all outputs are gated by the stage's valid.
- Load-use hazard (HAZARD_EN=1): ex_valid & ex_memRead & id_valid & (ex_rt == id_rs or ex_rt == id_rt) -> id_stall=1; ID/EX loads a bubble; ID instruction is held and re-decoded next cycle. ex_rt is id_rt registered into the EX slot.
- Flush: ex_valid & ex_branch & (branch_taken XOR ex_branchNe) -> ID/EX loads a bubble; id_stall forced 0 (flush wins over stall).
- EX/MEM and MEM/WB always advance; stalls never hold later stages.
- Illegal opcode enters EX as a bubble with ex_illegal=1 for that single cycle (ex_valid=0).

## Timing
- Reset: every output 0 immediately on reset low, independent of clk; all stage registers cleared; first valid ex_* one cycle after first rising edge with reset high.
- Latency: ID decode -> ex_* 1 cycle, -> mem_* 2 cycles, -> wb_* 3 cycles.
- id_stall is combinational from the EX register and ID inputs, same cycle as the hazard; lasts exactly one cycle per load-use pair.
- Reset asserted mid-stall or mid-flush: all in-flight slots discarded, no partial state retained.
- Back-to-back loads feeding each other: each pair stalls once.

## Structure
- Shared package mips_ctrl_pkg: opcode localparams (OP_RTYPE, OP_ADDI, OP_LW, OP_LH, OP_LHU, OP_SW, OP_BEQ, OP_BNE), aluOp codes, memSize enum, ctrl_t packed struct of the bundle.
- Sub-module ctrl_decode: pure combinational opcode -> ctrl_t; top holds the three stage registers and hazard/flush logic.

## Test plan
- Reset low during streaming traffic -> all outputs 0 within the same cycle, no clock needed.
- opcode 0x00 at cycle 0 -> cycle 1 ex_regDest=1, ex_aluOp=10; cycle 3 wb_regWrite=1, wb_memToReg=0.
- lw rt=9, then add rs=9 -> id_stall=1 for one cycle, bubble (ex_valid=0), add enters EX one cycle late; with HAZARD_EN=0 no stall.
- beq with branch_taken=1 in EX -> next ex_valid=0; bne with branch_taken=0 -> same squash; beq not taken -> no squash.
- Load-use hazard coinciding with taken branch -> id_stall=0, bubble inserted once.
- lh then lhu then opcode 0x3F -> mem_memSize 01 then 10; ex_illegal=1 one cycle with all controls 0.
